wb_nor_ctrl_multi: RTL and testbench
====================================

Name: wb_nor_ctrl_multi

Overview:
- Parametrised Wishbone (pipelined, 16-bit class) slave driving a parallel NOR flash bus across NUM_CS chip selects.
- Generalises the single-chip, fixed-timing NOR controller behind the bridge top.
- Adds programmable setup/access/hold timing, per-chip CE decode, synchronised ready/busy wait after writes, and optional busy timeout.
- Sits between the QSPI-to-Wishbone front end and the NOR pads.

Parameters:
- DATA_W, 16: NOR and Wishbone data width.
- ADDR_W, 26: NOR word-address width.
- CS_W, 1: chip-select index bits; NUM_CS = 2**CS_W.
- T_SETUP, 2: cycles with address/CE valid before the strobe; min 1.
- T_ACCESS, 4: cycles OE# or WE# is held low; min 1.
- T_HOLD, 1: cycles CE held after the strobe deasserts; min 1.
- RY_TIMEOUT, 4096: busy-wait limit in cycles; used only with NOR_RY_TIMEOUT_EN.

Ports:
- clk_i  in  1  system clock.
- reset_i  in  1  synchronous active-high reset.
- wb_adr_i  in  ADDR_W+CS_W  {cs index, word address}.
- wb_dat_i  in  DATA_W  write data.
- wb_we_i, wb_stb_i, wb_cyc_i  in  1 each  Wishbone control.
- wb_ack_o  out  1  one-cycle acknowledge.
- wb_err_o  out  1  one-cycle error (timeout).
- wb_stall_o  out  1  pipelined stall.
- wb_dat_o  out  DATA_W  registered read data.
- nor_ry_i  in  1  asynchronous ready/busy#, high = ready.
- nor_data_i  in  DATA_W  NOR data in.
- nor_data_o  out  DATA_W  NOR data out.
- nor_addr_o  out  ADDR_W  NOR address.
- nor_ce_o  out  NUM_CS  active-low chip enables.
- nor_we_o, nor_oe_o  out  1 each  active-low strobes.
- nor_data_oe  out  1  pad output enable.

Behaviour:
- Reset (sync, active high, 1 = reset): state IDLE; nor_ce_o all ones; nor_we_o=1; nor_oe_o=1; nor_data_oe=0; nor_addr_o=0; nor_data_o=0; wb_dat_o=0; wb_ack_o=0; wb_err_o=0; wb_stall_o=1 for the reset cycle, then 0 in IDLE. Reset mid-transaction aborts immediately; outputs take reset values on the next edge.
- nor_ry_i passes through a 2-flop synchroniser; ry_s denotes the synchronised value.
- wb_stall_o = (state != IDLE) | !ry_s.
- Accept: stb & cyc & !stall. On accept, latch address, chip-select index, write data and we.
- State sequence: IDLE -> SETUP (T_SETUP cyc) -> ACCESS (T_ACCESS cyc) -> HOLD (T_HOLD cyc) -> reads go to DONE; writes go to RYWAIT -> DONE -> IDLE. A single 8-bit down-counter is reloaded on each state entry.
- SETUP: selected nor_ce_o bit low, nor_addr_o valid; writes also drive nor_data_oe=1 and nor_data_o=data.
- ACCESS: read drives nor_oe_o=0; write drives nor_we_o=0. On the last ACCESS cycle a read registers nor_data_i into wb_dat_o.
- HOLD: strobes high; CE, address and data_oe unchanged.
- RYWAIT: CE all high; nor_data_oe=0. First ignore ry_s for 3 cycles (busy-assert guard), then wait for ry_s=1.
- DONE: wb_ack_o=1 for exactly one cycle if cyc_i is still high. If cyc_i dropped mid-operation, the NOR cycle still completes and the ack is suppressed.
- Read latency: accept at cycle N gives ack at N+1+T_SETUP+T_ACCESS+T_HOLD. With defaults, N+8.
- Back-to-back: the next request is accepted in the cycle after DONE, at the earliest.
- Only one chip enable is ever low at a time. Chip-select index decodes one-hot.

Optional Feature:
- Macro: NOR_RY_TIMEOUT_EN.
- Defined: RYWAIT counts up to RY_TIMEOUT cycles. On expiry, assert wb_err_o for one cycle instead of wb_ack_o (gated by cyc_i), then return to IDLE. wb_stall_o then follows ry_s.
- Undefined: RYWAIT waits indefinitely; wb_err_o is tied 0.

Test Plan:
- Read, defaults: accept at cycle 0, addr 0x0123456, cs 1 -> nor_ce_o=2'b01 over cycles 1-7; nor_oe_o low over cycles 3-6; nor_data_i=0xBEEF -> wb_ack_o high at cycle 8 only, wb_dat_o=0xBEEF.
- Write 0x00AA to cs 0 -> nor_we_o low for 4 cycles; nor_data_oe high over SETUP..HOLD. Hold ry low for 20 cycles -> ack 1 cycle after ry_s rises, never before; wb_stall_o high throughout.
- Two pipelined reads with stb held -> second accepted the cycle after the first ack; nor_ce_o returns high for at least one cycle between them.
- cyc_i dropped during ACCESS -> strobe sequence completes unchanged; no ack; IDLE afterwards.
- NOR_RY_TIMEOUT_EN, RY_TIMEOUT=16, ry held low -> wb_err_o pulses 1 cycle, no ack. Without the macro -> no err, stall stays high.
- reset_i asserted during ACCESS of a write -> next edge: nor_we_o=1, nor_ce_o all ones, nor_data_oe=0, no ack.

Source files
------------

// File: rtl/wb_nor_ctrl_multi.sv
// Pipelined Wishbone slave driving a parallel NOR bus over NUM_CS chips with programmable timing.
// Optional busy-wait timeout (wb_err_o) is built only when NOR_RY_TIMEOUT_EN is defined.
module wb_nor_ctrl_multi #(
   parameter int DATA_W     = 16,
   parameter int ADDR_W     = 26,
   parameter int CS_W       = 1,
   parameter int T_SETUP    = 2,
   parameter int T_ACCESS   = 4,
   parameter int T_HOLD     = 1,
   parameter int RY_TIMEOUT = 4096
) (
   input  logic                      clk_i,
   input  logic                      reset_i,
   input  logic [ADDR_W+CS_W-1:0]    wb_adr_i,
   input  logic [DATA_W-1:0]         wb_dat_i,
   input  logic                      wb_we_i,
   input  logic                      wb_stb_i,
   input  logic                      wb_cyc_i,
   output logic                      wb_ack_o,
   output logic                      wb_err_o,
   output logic                      wb_stall_o,
   output logic [DATA_W-1:0]         wb_dat_o,
   input  logic                      nor_ry_i,
   input  logic [DATA_W-1:0]         nor_data_i,
   output logic [DATA_W-1:0]         nor_data_o,
   output logic [ADDR_W-1:0]         nor_addr_o,
   output logic [(1<<CS_W)-1:0]      nor_ce_o,
   output logic                      nor_we_o,
   output logic                      nor_oe_o,
   output logic                      nor_data_oe
);
   localparam int NUM_CS = 1 << CS_W;
   localparam int TO_W   = $clog2(RY_TIMEOUT + 1);
   // Flash takes a few cycles to pull RY/BY# low after a program command.
   localparam logic [7:0] RY_GUARD = 8'd3;

   typedef enum logic [2:0] {IDLE, SETUP, ACCESS, HOLD, RYWAIT, DONE} state_t;

   state_t            state_q, state_d;
   logic [7:0]        cnt_q, cnt_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [CS_W-1:0]   cs_q, cs_d;
   logic [DATA_W-1:0] wdat_q, wdat_d;
   logic [DATA_W-1:0] rdat_q, rdat_d;
   logic              we_q, we_d;
   logic              abort_q, abort_d;
   logic              err_q, err_d;
   logic              ry_meta_q, ry_meta_d;
   logic              ry_s_q, ry_s_d;
   logic [TO_W-1:0]   to_cnt_q, to_cnt_d;

   logic              stall;
   logic              accept;
   logic              cnt_zero;
   logic [NUM_CS-1:0] cs_onehot;

   assign stall    = reset_i | (state_q != IDLE) | ~ry_s_q;
   assign accept   = wb_stb_i & wb_cyc_i & ~stall;
   assign cnt_zero = (cnt_q == 8'd0);

   for (genvar gi = 0; gi < NUM_CS; gi++) begin : g_cs_dec
      assign cs_onehot[gi] = (cs_q == CS_W'(gi));
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q   <= IDLE;
         cnt_q     <= 8'd0;
         addr_q    <= '0;
         cs_q      <= '0;
         wdat_q    <= '0;
         rdat_q    <= '0;
         we_q      <= 1'b0;
         abort_q   <= 1'b0;
         err_q     <= 1'b0;
         ry_meta_q <= 1'b1;
         ry_s_q    <= 1'b1;
         to_cnt_q  <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         addr_q    <= addr_d;
         cs_q      <= cs_d;
         wdat_q    <= wdat_d;
         rdat_q    <= rdat_d;
         we_q      <= we_d;
         abort_q   <= abort_d;
         err_q     <= err_d;
         ry_meta_q <= ry_meta_d;
         ry_s_q    <= ry_s_d;
         to_cnt_q  <= to_cnt_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      addr_d    = addr_q;
      cs_d      = cs_q;
      wdat_d    = wdat_q;
      rdat_d    = rdat_q;
      we_d      = we_q;
      abort_d   = abort_q;
      err_d     = err_q;
      ry_meta_d = nor_ry_i;
      ry_s_d    = ry_meta_q;
      to_cnt_d  = to_cnt_q;
      unique case (state_q)
         IDLE: begin
            if (accept) begin
               addr_d  = wb_adr_i[ADDR_W-1:0];
               cs_d    = wb_adr_i[ADDR_W +: CS_W];
               wdat_d  = wb_dat_i;
               we_d    = wb_we_i;
               abort_d = 1'b0;
               err_d   = 1'b0;
               cnt_d   = 8'(T_SETUP - 1);
               state_d = SETUP;
            end
         end
         SETUP: begin
            if (cnt_zero) begin
               cnt_d   = 8'(T_ACCESS - 1);
               state_d = ACCESS;
            end else begin
               cnt_d = cnt_q - 8'd1;
            end
         end
         ACCESS: begin
            if (cnt_zero) begin
               if (!we_q) rdat_d = nor_data_i;
               cnt_d   = 8'(T_HOLD - 1);
               state_d = HOLD;
            end else begin
               cnt_d = cnt_q - 8'd1;
            end
         end
         HOLD: begin
            if (cnt_zero) begin
               cnt_d    = RY_GUARD;
               to_cnt_d = '0;
               state_d  = we_q ? RYWAIT : DONE;
            end else begin
               cnt_d = cnt_q - 8'd1;
            end
         end
         RYWAIT: begin
            to_cnt_d = to_cnt_q + TO_W'(1);
            if (!cnt_zero) cnt_d = cnt_q - 8'd1;
            if (cnt_zero && ry_s_q) begin
               state_d = DONE;
            end
`ifdef NOR_RY_TIMEOUT_EN
            else if (to_cnt_q == TO_W'(RY_TIMEOUT - 1)) begin
               err_d   = 1'b1;
               state_d = DONE;
            end
`endif
         end
         DONE: state_d = IDLE;
         default: state_d = IDLE;
      endcase
      // A master that drops cyc mid-operation forfeits its response.
      if (state_q != IDLE && !wb_cyc_i) abort_d = 1'b1;
   end

   always_comb begin
      nor_ce_o    = '1;
      nor_we_o    = 1'b1;
      nor_oe_o    = 1'b1;
      nor_data_oe = 1'b0;
      wb_ack_o    = 1'b0;
      wb_err_o    = 1'b0;
      unique case (state_q)
         SETUP, HOLD: begin
            nor_ce_o    = ~cs_onehot;
            nor_data_oe = we_q;
         end
         ACCESS: begin
            nor_ce_o    = ~cs_onehot;
            nor_data_oe = we_q;
            nor_oe_o    = we_q;
            nor_we_o    = ~we_q;
         end
         DONE: begin
            wb_ack_o = wb_cyc_i & ~abort_q & ~err_q;
`ifdef NOR_RY_TIMEOUT_EN
            wb_err_o = wb_cyc_i & ~abort_q & err_q;
`else
            wb_err_o = 1'b0;
`endif
         end
         default: ;
      endcase
   end

   assign wb_stall_o = stall;
   assign wb_dat_o   = rdat_q;
   assign nor_addr_o = addr_q;
   assign nor_data_o = wdat_q;

endmodule

// File: tb/tb_wb_nor_ctrl_multi.sv
// Bench for wb_nor_ctrl_multi: cycle-offset model of the NOR bus timing plus directed scenarios.
// Honours NOR_RY_TIMEOUT_EN for the busy-timeout expectations.
module tb_wb_nor_ctrl_multi;
   localparam int DW = 16, AW = 26, CW = 1, NCS = 2;
   localparam int TS = 2, TA = 4, TH = 1, RYT = 16;
   localparam int L = TS + TA + TH;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic           reset_i = 1'b1;
   logic [AW+CW-1:0] wb_adr_i = '0;
   logic [DW-1:0]  wb_dat_i = '0;
   logic           wb_we_i = 1'b0, wb_stb_i = 1'b0, wb_cyc_i = 1'b0;
   logic           wb_ack_o, wb_err_o, wb_stall_o;
   logic [DW-1:0]  wb_dat_o;
   logic           nor_ry_i = 1'b1;
   logic [DW-1:0]  nor_data_i = '0;
   logic [DW-1:0]  nor_data_o;
   logic [AW-1:0]  nor_addr_o;
   logic [NCS-1:0] nor_ce_o;
   logic           nor_we_o, nor_oe_o, nor_data_oe;

   wb_nor_ctrl_multi #(
      .DATA_W(DW), .ADDR_W(AW), .CS_W(CW), .T_SETUP(TS), .T_ACCESS(TA),
      .T_HOLD(TH), .RY_TIMEOUT(RYT)
   ) dut (
      .clk_i(clk), .reset_i(reset_i), .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i),
      .wb_we_i(wb_we_i), .wb_stb_i(wb_stb_i), .wb_cyc_i(wb_cyc_i),
      .wb_ack_o(wb_ack_o), .wb_err_o(wb_err_o), .wb_stall_o(wb_stall_o),
      .wb_dat_o(wb_dat_o), .nor_ry_i(nor_ry_i), .nor_data_i(nor_data_i),
      .nor_data_o(nor_data_o), .nor_addr_o(nor_addr_o), .nor_ce_o(nor_ce_o),
      .nor_we_o(nor_we_o), .nor_oe_o(nor_oe_o), .nor_data_oe(nor_data_oe)
   );

   int n_chk = 0, n_pass = 0;
   int cur_cyc = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s cycle %0d: got %0h expected %0h", nm, cur_cyc, act, exp);
   endtask

   // Model state: one outstanding transaction described by its accept cycle.
   bit             m_act = 0, m_we, m_ok, m_err;
   int             m_n, m_done, k;
   logic [CW-1:0]  m_cs;
   logic [AW-1:0]  m_addr;
   logic [DW-1:0]  m_wd, exp_dat = '0, dat_next;
   logic [NCS-1:0] one_cs = 1, e_ce;
   bit             e_we, e_oe, e_doe, e_stall, e_ack, e_err, rs;
   bit             rst_h1 = 1, rst_h2 = 1, ry_h1 = 1, ry_h2 = 1;

   int ack_cnt, err_cnt, oe_low, we_low, ce_low, doe_high, first_ack;
   logic [NCS-1:0] ce_last_low, ce_at_ack;

   task automatic clear_stats();
      ack_cnt = 0; err_cnt = 0; oe_low = 0; we_low = 0; ce_low = 0; doe_high = 0;
      first_ack = -1; ce_last_low = '1; ce_at_ack = '0;
   endtask

   always @(negedge clk) begin
      rs = (rst_h1 || rst_h2) ? 1'b1 : ry_h2;
      dat_next = exp_dat;
      if (!reset_i) begin
         if (!nor_oe_o) oe_low++;
         if (!nor_we_o) we_low++;
         if (nor_ce_o != '1) begin ce_low++; ce_last_low = nor_ce_o; end
         if (nor_data_oe) doe_high++;
         if (wb_err_o) err_cnt++;
         if (wb_ack_o) begin
            if (ack_cnt == 0) begin first_ack = cur_cyc; ce_at_ack = nor_ce_o; end
            ack_cnt++;
         end
      end
      if (reset_i) begin
         chk("stall_in_reset", wb_stall_o, 1);
         m_act = 0;
         dat_next = '0;
      end else begin
         chk("wb_dat_o", wb_dat_o, exp_dat);
         e_ce = '1; e_we = 1; e_oe = 1; e_doe = 0; e_ack = 0; e_err = 0;
         e_stall = !rs;
         if (m_act) begin
            k = cur_cyc - m_n;
            e_stall = 1;
            m_ok = m_ok & wb_cyc_i;
            if (k >= 1 && k <= L) begin
               e_ce = ~(one_cs << m_cs);
               e_doe = m_we;
               chk("nor_addr_o", nor_addr_o, m_addr);
               if (m_we) chk("nor_data_o", nor_data_o, m_wd);
            end
            if (k >= TS + 1 && k <= TS + TA) begin
               if (m_we) e_we = 0; else e_oe = 0;
            end
            if (!m_we && k == TS + TA) dat_next = nor_data_i;
            if (!m_we && k == L) m_done = cur_cyc + 1;
            if (m_we && m_done < 0 && k > L) begin
               if (k >= L + 4 && rs) m_done = cur_cyc + 1;
`ifdef NOR_RY_TIMEOUT_EN
               else if (k - (L + 1) == RYT - 1) begin m_done = cur_cyc + 1; m_err = 1; end
`endif
            end
            if (cur_cyc == m_done) begin
               e_ack = m_ok & !m_err;
               e_err = m_ok & m_err;
               m_act = 0;
            end
         end else if (wb_stb_i && wb_cyc_i && rs) begin
            m_act = 1; m_n = cur_cyc; m_done = -1; m_ok = 1; m_err = 0;
            m_we = wb_we_i; m_cs = wb_adr_i[AW +: CW];
            m_addr = wb_adr_i[AW-1:0]; m_wd = wb_dat_i;
         end
         chk("nor_ce_o", nor_ce_o, e_ce);
         chk("nor_we_o", nor_we_o, e_we);
         chk("nor_oe_o", nor_oe_o, e_oe);
         chk("nor_data_oe", nor_data_oe, e_doe);
         chk("wb_stall_o", wb_stall_o, e_stall);
         chk("wb_ack_o", wb_ack_o, e_ack);
         chk("wb_err_o", wb_err_o, e_err);
      end
      exp_dat = dat_next;
      rst_h2 = rst_h1; rst_h1 = reset_i;
      ry_h2 = ry_h1; ry_h1 = nor_ry_i;
      cur_cyc++;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input bit we, input logic [CW-1:0] cs, input logic [AW-1:0] a,
                        input logic [DW-1:0] d, input bit keep_stb, output int acc_c);
      wb_we_i = we; wb_adr_i = {cs, a}; wb_dat_i = d; wb_stb_i = 1; wb_cyc_i = 1;
      acc_c = -1;
      for (int i = 0; i < 100; i++) begin
         #2;
         if (!wb_stall_o) acc_c = cur_cyc;
         tick();
         if (acc_c >= 0) break;
      end
      if (!keep_stb) wb_stb_i = 0;
      if (acc_c < 0) chk("accept_timeout", 0, 1);
   endtask

   task automatic wait_resp(input int max, output int resp_c);
      resp_c = -1;
      for (int i = 0; i < max; i++) begin
         #2;
         if (wb_ack_o || wb_err_o) resp_c = cur_cyc;
         tick();
         if (resp_c >= 0) break;
      end
      if (resp_c < 0) chk("response_timeout", 0, 1);
   endtask

   int acc, acc2, resp, rise;

   initial begin
      clear_stats();
      tick(); tick(); tick();
      reset_i = 0;
      #2;
      chk("rst_ce", nor_ce_o, 2'b11);
      chk("rst_addr", nor_addr_o, 0);
      chk("rst_data_o", nor_data_o, 0);
      chk("rst_dat_o", wb_dat_o, 0);
      chk("rst_stall_idle", wb_stall_o, 0);
      tick();

      // Read cs1
      clear_stats();
      nor_data_i = 16'hBEEF;
      issue(0, 1'b1, 26'h0123456, 16'h0, 0, acc);
      wait_resp(50, resp);
      wb_cyc_i = 0;
      $display("read cs1: accept %0d ack %0d data %h", acc, resp, wb_dat_o);
      chk("read_latency", resp - acc, 8);
      chk("read_ack_cnt", ack_cnt, 1);
      chk("read_ce_cycles", ce_low, 7);
      chk("read_ce_val", ce_last_low, 2'b01);
      chk("read_oe_cycles", oe_low, 4);
      chk("read_we_cycles", we_low, 0);
      chk("read_data", wb_dat_o, 16'hBEEF);
      tick();

      // Write cs0 with ry busy for 20 cycles
      clear_stats();
      issue(1, 1'b0, 26'h0000055, 16'h00AA, 0, acc);
      nor_ry_i = 0;
      for (int i = 0; i < 20; i++) tick();
      nor_ry_i = 1;
      rise = cur_cyc;
      wait_resp(50, resp);
      wb_cyc_i = 0;
      $display("write cs0: accept %0d ry rise %0d ack %0d", acc, rise, resp);
      chk("write_ack_after_ry", resp - rise, 3);
      chk("write_we_cycles", we_low, 4);
      chk("write_doe_cycles", doe_high, 7);
      chk("write_oe_cycles", oe_low, 0);
      chk("write_ack_cnt", ack_cnt, 1);
      tick();

      // Two pipelined reads, stb held throughout
      clear_stats();
      nor_data_i = 16'h1234;
      issue(0, 1'b0, 26'h0000100, 16'h0, 1, acc);
      issue(0, 1'b1, 26'h0000200, 16'h0, 0, acc2);
      wait_resp(50, resp);
      wb_cyc_i = 0;
      $display("pipelined reads: accept %0d/%0d acks at %0d/%0d", acc, acc2, first_ack, resp);
      chk("pipe_second_accept", acc2 - acc, 9);
      chk("pipe_accept_after_ack", acc2 - first_ack, 1);
      chk("pipe_ce_high_at_ack", ce_at_ack, 2'b11);
      chk("pipe_ack_cnt", ack_cnt, 2);
      chk("pipe_data", wb_dat_o, 16'h1234);
      tick();

      // cyc dropped during ACCESS
      clear_stats();
      issue(0, 1'b1, 26'h3FFFFFF, 16'h0, 0, acc);
      tick(); tick();
      wb_cyc_i = 0;
      for (int i = 0; i < 12; i++) tick();
      #2;
      $display("cyc drop: accept %0d acks %0d oe cycles %0d", acc, ack_cnt, oe_low);
      chk("drop_ack_cnt", ack_cnt, 0);
      chk("drop_oe_cycles", oe_low, 4);
      chk("drop_ce_cycles", ce_low, 7);
      chk("drop_idle_stall", wb_stall_o, 0);
      tick();

      // Flash stays busy for a long time
      clear_stats();
      issue(1, 1'b1, 26'h0000ABC, 16'h5A5A, 0, acc);
      nor_ry_i = 0;
      for (int i = 0; i < 40; i++) tick();
      #2;
      $display("busy hold: accept %0d acks %0d errs %0d stall %0b", acc, ack_cnt, err_cnt, wb_stall_o);
      chk("busy_ack_cnt", ack_cnt, 0);
      chk("busy_stall", wb_stall_o, 1);
`ifdef NOR_RY_TIMEOUT_EN
      chk("busy_err_cnt", err_cnt, 1);
      tick();
      nor_ry_i = 1;
      for (int i = 0; i < 5; i++) tick();
      #2;
      chk("busy_stall_after_ry", wb_stall_o, 0);
      tick();
`else
      chk("busy_err_cnt", err_cnt, 0);
      tick();
      nor_ry_i = 1;
      wait_resp(20, resp);
      chk("busy_late_ack", ack_cnt, 1);
`endif
      wb_cyc_i = 0;
      tick();

      // Reset during ACCESS of a write
      clear_stats();
      issue(1, 1'b1, 26'h0001111, 16'hC3C3, 0, acc);
      tick(); tick(); tick();
      reset_i = 1;
      tick();
      reset_i = 0;
      #2;
      $display("reset mid-write: accept %0d we %0b ce %b doe %0b", acc, nor_we_o, nor_ce_o, nor_data_oe);
      chk("rstw_we", nor_we_o, 1);
      chk("rstw_ce", nor_ce_o, 2'b11);
      chk("rstw_doe", nor_data_oe, 0);
      chk("rstw_ack", wb_ack_o, 0);
      for (int i = 0; i < 10; i++) tick();
      chk("rstw_ack_cnt", ack_cnt, 0);
      wb_cyc_i = 0;
      tick();

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish, %0d/%0d", n_pass, n_chk);
      $fatal(1, "watchdog");
   end
endmodule
